// File: rtl/score_keeper_param.sv
// -----------------------------------------------------------------------------
// score_keeper_param
//   Parametrised BCD score / difficulty unit for the dino game.
//   Keeps an N-digit BCD score that advances once every TICK_DIV clocks while
//   the game is running. It also keeps a high-score register with a new-record
//   flag, a saturating difficulty level, overflow handling (saturate or wrap),
//   and a registered seven-segment display of either the current or the high
//   score, with optional leading-zero blanking.
//
// Ports
//   clk        in   1            board clock
//   rst        in   1            asynchronous reset, active low
//   game_state in   2            0 start, 1 running, 2 game over, 3 behaves as 0
//   show_high  in   1            1: display high score, 0: display current score
//   score_bcd  out  4*DIGITS     current score, digit i at [4i+3:4i]
//   high_bcd   out  4*DIGITS     best score since reset
//   level      out  LEVEL_W      difficulty level (feeds obstacle speed logic)
//   new_high   out  1            sticky: last game set a new record
//   overflow   out  1            sticky: score was all-9s and tried to increment
//   hex        out  7*DIGITS     active-low segments {g..a}, digit i at [7i+6:7i]
// -----------------------------------------------------------------------------
module score_keeper_param #(
    parameter int DIGITS         = 6,
    parameter int TICK_DIV       = 5000000,
    parameter bit WRAP           = 1'b0,
    parameter int LEVEL_STEP_DIG = 2,
    parameter int LEVEL_W        = 3,
    parameter int LEVEL_MAX      = 7,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            game_state,
    input  logic                  show_high,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic [LEVEL_W-1:0]    level,
    output logic                  new_high,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int SW    = 4 * DIGITS;
    localparam int HW    = 7 * DIGITS;
    localparam int PW    = $clog2(TICK_DIV);
    localparam int LOW_W = 4 * LEVEL_STEP_DIG;

    localparam logic [PW-1:0]      PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX    = LEVEL_W'(LEVEL_MAX);

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_OVER  = 2'd2;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // BCD ripple increment: a 9 becomes 0 and carries into the next digit.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
                carry       = 1'b0;
            end
        end
        return r;
    endfunction

    // True when every digit holds 9 (the increment would overflow).
    function automatic logic all_nines(input logic [SW-1:0] v);
        logic r;
        r = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) begin
                r = 1'b0;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Most-significant-digit-first magnitude compare: a > b.
    function automatic logic bcd_gt(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic decided;
        logic gt;
        decided = 1'b0;
        gt      = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                decided = 1'b1;
                gt      = (a[4*i +: 4] > b[4*i +: 4]);
            end else begin
                decided = decided;
                gt      = gt;
            end
        end
        return gt;
    endfunction

    // Active-low {g..a} segment pattern; anything outside 0..9 is dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Display pattern for a score of zero: digit 0 shows '0', the others
    // are dark when leading-zero blanking is on.
    function automatic logic [HW-1:0] hex_rst_val();
        logic [HW-1:0] v;
        v = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (BLANK_LZ && (i != 0)) begin
                v[7*i +: 7] = 7'h7F;
            end else begin
                v[7*i +: 7] = 7'b1000000;
            end
        end
        return v;
    endfunction

    localparam logic [HW-1:0] HEX_RST = hex_rst_val();

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SW-1:0]      score_q, score_d;
    logic [SW-1:0]      high_q, high_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               new_high_q, new_high_d;
    logic               overflow_q, overflow_d;
    logic [1:0]         prev_q, prev_d;
    logic [HW-1:0]      hex_q, hex_d;

    logic [1:0]         state_s;
    logic               tick_s;
    logic [SW-1:0]      inc_s;
    logic               nines_s;
    logic               go_edge_s;
    logic               step_s;
    logic [SW-1:0]      disp_src_s;
    logic               lit_s;

    // Score, prescaler, level, overflow and high-score next-state logic.
    always_comb begin
        // Encoding 3 is an alias of the start state.
        state_s   = (game_state == 2'd3) ? ST_START : game_state;
        tick_s    = (state_s == ST_RUN) && (presc_q == PRESC_LAST);
        inc_s     = bcd_inc(score_q);
        nines_s   = all_nines(score_q);
        go_edge_s = (prev_q == ST_RUN) && (state_s == ST_OVER);
        step_s    = 1'b0;

        score_d    = score_q;
        high_d     = high_q;
        presc_d    = presc_q;
        level_d    = level_q;
        new_high_d = new_high_q;
        overflow_d = overflow_q;
        prev_d     = state_s;

        case (state_s)
            ST_RUN: begin
                if (tick_s) begin
                    presc_d = '0;
                    if (nines_s) begin
                        overflow_d = 1'b1;
                        score_d    = WRAP ? '0 : score_q;
                    end else begin
                        score_d    = inc_s;
                    end
                    // A saturated score is unchanged, so it never steps the level.
                    step_s = (score_d != score_q) && (score_d[LOW_W-1:0] == '0);
                    if (step_s && (level_q < LVL_MAX)) begin
                        level_d = level_q + LEVEL_W'(1);
                    end else begin
                        level_d = level_q;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_OVER: begin
                // Score and prescaler are frozen; only the run->over edge
                // may record a new best score.
                if (go_edge_s && bcd_gt(score_q, high_q)) begin
                    high_d     = score_q;
                    new_high_d = 1'b1;
                end else begin
                    high_d     = high_q;
                    new_high_d = new_high_q;
                end
            end
            default: begin
                score_d    = '0;
                presc_d    = '0;
                level_d    = '0;
                overflow_d = 1'b0;
                new_high_d = 1'b0;
            end
        endcase
    end

    // Display source selection, decode and leading-zero blanking.
    always_comb begin
        disp_src_s = show_high ? high_q : score_q;
        lit_s      = 1'b0;
        hex_d      = '0;
        // Walk from the top digit down; once a non-zero digit is seen every
        // lower digit is lit. Digit 0 is always lit.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (disp_src_s[4*i +: 4] != 4'd0) begin
                lit_s = 1'b1;
            end else begin
                lit_s = lit_s;
            end
            if (BLANK_LZ && !lit_s && (i != 0)) begin
                hex_d[7*i +: 7] = 7'h7F;
            end else begin
                hex_d[7*i +: 7] = seg_decode(disp_src_s[4*i +: 4]);
            end
        end
    end

    // State registers with asynchronous active-low clear (high score included).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score_q    <= '0;
            high_q     <= '0;
            presc_q    <= '0;
            level_q    <= '0;
            new_high_q <= 1'b0;
            overflow_q <= 1'b0;
            prev_q     <= ST_START;
            hex_q      <= HEX_RST;
        end else begin
            score_q    <= score_d;
            high_q     <= high_d;
            presc_q    <= presc_d;
            level_q    <= level_d;
            new_high_q <= new_high_d;
            overflow_q <= overflow_d;
            prev_q     <= prev_d;
            hex_q      <= hex_d;
        end
    end

    assign score_bcd = score_q;
    assign high_bcd  = high_q;
    assign level     = level_q;
    assign new_high  = new_high_q;
    assign overflow  = overflow_q;
    assign hex       = hex_q;

endmodule
